axi_slave_wr_ctrl: RTL

AXI_SLAVE_WR_CTRL -- requirements
Module: axi_slave_wr_ctrl

---
 rtl/axi_slave_wr_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_slave_wr_ctrl.sv
// AXI write-channel slave controller: accepts one burst at a time, generates
// per-beat memory write strobes/addresses and returns a single B response.
module axi_slave_wr_ctrl #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]            MAX_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                state, state_nx;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            cnt_q;
    logic                  err_q;

    logic                  aw_hs, w_hs, b_hs, last_beat;
    logic                  aw_err, beat_err, err_d, we_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [ADDR_WIDTH-1:0] aw_base, inc, cmask, next_addr;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (aw_hs) state_nx = DATA;
            DATA:    if (w_hs && last_beat) state_nx = RESP;
            RESP:    if (b_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        awready_d = (state_nx == IDLE);
        wready_d  = (state_nx == DATA);
        bvalid_d  = (state_nx == RESP);

        aw_base = awaddr & ~((ONE << awsize) - ONE);
        aw_err  = (awburst == 2'b11) || (awsize > MAX_SIZE) ||
                  ((awburst == 2'b10) &&
                   !((awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15)));

        beat_err = 1'b0;
        err_d    = err_q;
        we_d     = 1'b0;
        if (w_hs) begin
            beat_err = last_beat ? !wlast : wlast;
            err_d    = err_q || beat_err;
            we_d     = !err_q && !beat_err;
        end

        // WRAP container mask is only meaningful for legal lengths; illegal ones never write
        inc   = ONE << size_q;
        cmask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
        case (burst_q)
            2'b01:   next_addr = addr_q + inc;
            2'b10:   next_addr = (addr_q & ~cmask) | ((addr_q + inc) & cmask);
            default: next_addr = addr_q;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            mem_we  <= we_d;
            if (aw_hs) begin
                id_q    <= awid;
                addr_q  <= aw_base;
                len_q   <= awlen;
                size_q  <= awsize;
                burst_q <= awburst;
                cnt_q   <= '0;
                err_q   <= aw_err;
            end
            if (w_hs) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= next_addr;
                err_q  <= err_d;
            end
            if (we_d) begin
                mem_addr  <= addr_q;
                mem_wdata <= wdata;
                mem_wstrb <= wstrb;
            end
            if (w_hs && last_beat) begin
                bid   <= id_q;
                bresp <= err_d ? 2'b10 : 2'b00;
            end
        end
    end

endmodule
